uart_recv: RTL and testbench

UART receiver, the receive-side counterpart of `uart_send`, for 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle line high. It synchronises the asynchronous serial input, detects the start edge, samples each bit at mid-period using an internal bit-period counter, and presents the received byte with a one-cycle valid strobe. It sits between the board RX pin and the character consumer, and shares the line format and `character` naming with `uart_send`.

---
 rtl/uart_recv_pkg.sv | 21 ++
 rtl/uart_sync.sv | 24 ++
 rtl/uart_recv.sv | 140 ++++++++++++++
 tb/tb_uart_recv.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_recv_pkg.sv
// Shared 8N1 line-format constants and receiver FSM state encoding.
// The same frame definitions are meant to be reused by uart_send.
package uart_recv_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W      = $clog2(UART_DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Mid-bit offset used to centre sampling on each bit.
    function automatic int unsigned half_period(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Reset value is a parameter so idle-high and idle-low lines can both use it.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ff <= {2{RST_VAL}};
        end else begin
            r_ff <= {r_ff[0], i_async};
        end
    end

    assign o_sync = r_ff[1];

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: synchronises the RX pin, centres on each bit with a period
// counter and strobes valid (good stop bit) or frame_err (stop bit low).
module uart_recv
    import uart_recv_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signal,
    output logic [UART_DATA_BITS-1:0] character,
    output logic                      valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = half_period(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]     HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]     FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(UART_DATA_BITS - 1);

    if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_param_check
        $error("uart_recv: CLKS_PER_BIT must be even and at least 4");
    end

    logic w_rx_s;

    rx_state_t                 r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [BIT_IDX_W-1:0]      r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shreg;
    logic [UART_DATA_BITS-1:0] r_character;
    logic                      r_valid;
    logic                      r_frame_err;
    logic                      r_busy;

    uart_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (signal),
        .o_sync  (w_rx_s)
    );

    // Receiver FSM; busy is updated alongside every transition into or out of IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_character <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shreg <= {w_rx_s, r_shreg[UART_DATA_BITS-1:1]};
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_character <= r_shreg;
                            r_valid     <= 1'b1;
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                // A held-low line must return high before a new start edge counts.
                ST_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign character = r_character;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_recv.sv
// Directed and randomised 8N1 frames against a frame-level model of uart_recv.
// Strobes are logged with their cycle stamp and compared to times derived from the line format.
module tb_uart_recv;

    localparam int unsigned CPB  = 8;
    localparam int unsigned HALF = CPB / 2;
    // From the cycle stamp where the start bit is driven to the cycle valid/frame_err is seen.
    localparam int unsigned LAT  = 1 + 2 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sig = 1'b1;
    logic [7:0] character;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int unsigned cyc = 0;
    int unsigned v_t[$];
    logic [7:0]  v_c[$];
    int unsigned fe_t[$];
    int unsigned n_overlap = 0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned v_rd  = 0;
    int unsigned fe_rd = 0;
    logic [7:0]  exp_char = 8'h00;

    uart_recv #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .signal    (sig),
        .character (character),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            v_t.push_back(cyc);
            v_c.push_back(character);
        end
        if (frame_err) fe_t.push_back(cyc);
        if (valid && frame_err) n_overlap = n_overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int unsigned n);
        sig = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start, 8 data bits LSB first, then either a good stop bit or stop_low_bits periods of low line.
    task automatic send_frame(input logic [7:0] d, input int unsigned stop_low_bits, output int unsigned t0);
        t0 = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        if (stop_low_bits == 0) hold(1'b1, CPB);
        else hold(1'b0, stop_low_bits * CPB);
    endtask

    task automatic expect_valid(input string tag, input int unsigned t0, input logic [7:0] d);
        check({tag, "_valid_seen"}, 32'(v_t.size() > v_rd), 32'd1);
        if (v_t.size() > v_rd) begin
            check({tag, "_valid_time"}, v_t[v_rd], t0 + LAT);
            check({tag, "_char"}, 32'(v_c[v_rd]), 32'(d));
            v_rd = v_rd + 1;
        end
    endtask

    task automatic expect_fe(input string tag, input int unsigned t0);
        check({tag, "_fe_seen"}, 32'(fe_t.size() > fe_rd), 32'd1);
        if (fe_t.size() > fe_rd) begin
            check({tag, "_fe_time"}, fe_t[fe_rd], t0 + LAT);
            fe_rd = fe_rd + 1;
        end
    endtask

    task automatic expect_quiet(input string tag);
        check({tag, "_no_valid"}, v_t.size() - v_rd, 32'd0);
        check({tag, "_no_fe"}, fe_t.size() - fe_rd, 32'd0);
    endtask

    initial begin
        int unsigned t0;
        int unsigned t1;
        int unsigned busy_cnt;
        logic [7:0]  d;
        logic        bad;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_char", 32'(character), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_fe", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        hold(1'b1, CPB);

        // Single frame 0x64 followed by idle
        send_frame(8'h64, 0, t0);
        exp_char = 8'h64;
        expect_valid("f64", t0, exp_char);
        check("f64_busy_after", 32'(busy), 32'd0);
        hold(1'b1, 2 * CPB);
        check("f64_char_hold", 32'(character), 32'(exp_char));
        expect_quiet("f64");

        // Back-to-back frames with zero idle bits
        send_frame(8'h00, 0, t0);
        send_frame(8'hFF, 0, t1);
        check("b2b_spacing", t1 - t0, 32'd80);
        expect_valid("b2b0", t0, 8'h00);
        expect_valid("b2b1", t1, 8'hFF);
        exp_char = 8'hFF;
        hold(1'b1, 2 * CPB);
        check("b2b_char", 32'(character), 32'(exp_char));
        expect_quiet("b2b");

        // Short low glitch is rejected
        busy_cnt = 0;
        sig = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
        end
        sig = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
        end
        check("glitch_busy_seen", 32'(busy_cnt > 0), 32'd1);
        check("glitch_busy_bound", 32'(busy_cnt <= HALF + 1), 32'd1);
        check("glitch_busy_end", 32'(busy), 32'd0);
        check("glitch_char", 32'(character), 32'(exp_char));
        expect_quiet("glitch");

        // Good frame, then a frame whose stop bit is a long break
        send_frame(8'h5A, 0, t0);
        exp_char = 8'h5A;
        expect_valid("f5a", t0, exp_char);
        send_frame(8'hA5, 20, t0);
        expect_fe("brk", t0);
        check("brk_busy_low_line", 32'(busy), 32'd1);
        check("brk_char_kept", 32'(character), 32'(exp_char));
        expect_quiet("brk_during");
        hold(1'b1, 2 * CPB);
        check("brk_busy_released", 32'(busy), 32'd0);
        check("brk_char_after", 32'(character), 32'(exp_char));
        expect_quiet("brk_after");

        // Reset in the middle of frame 0x81
        d = 8'h81;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(d[i], CPB);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_char", 32'(character), 32'h00);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_fe", 32'(frame_err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        exp_char = 8'h00;
        hold(1'b1, 2 * CPB);
        expect_quiet("mid_rst");
        send_frame(8'h3C, 0, t0);
        exp_char = 8'h3C;
        expect_valid("f3c", t0, exp_char);

        // Randomised frames, some with a low stop bit, random idle gaps
        for (int n = 0; n < 12; n++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(d, bad ? 1 : 0, t0);
            if (bad) begin
                expect_fe($sformatf("rnd%0d", n), t0);
                hold(1'b1, CPB);
            end else begin
                exp_char = d;
                expect_valid($sformatf("rnd%0d", n), t0, d);
            end
            check($sformatf("rnd%0d_char", n), 32'(character), 32'(exp_char));
            hold(1'b1, $urandom_range(0, 12));
        end
        hold(1'b1, 2 * CPB);
        expect_quiet("rnd_end");
        check("strobe_overlap", n_overlap, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
